multiwave_generator: RTL

MULTIWAVE_GENERATOR -- requirements
Module: multiwave_generator

---
 rtl/multiwave_generator.sv | 129 ++++++++++++
 1 files changed

// File: rtl/multiwave_generator.sv
`default_nettype none
// ============================================================================
//  Module      : multiwave_generator
//  Description : Prescaled triangle / sawtooth / square level generator that
//                feeds a registered duty value to a downstream PWM stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiwave_generator #(
    parameter int DW    = 7,
    parameter int PRE_W = 6,
    parameter int STEP  = 2
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [PRE_W-1:0] scale,
    input  logic [DW-1:0]    peak,
    output logic [DW-1:0]    duty_out,
    output logic             dir,
    output logic             period_pulse
);

    localparam logic [1:0] c_TRI  = 2'b00;
    localparam logic [1:0] c_SAW  = 2'b01;
    localparam logic [1:0] c_SQR  = 2'b10;
    localparam logic [1:0] c_HOLD = 2'b11;
    localparam logic [DW:0] c_STEP = (DW+1)'(STEP);

    logic [PRE_W-1:0] r_pre_cnt;
    logic [DW-1:0]    r_level;
    logic [1:0]       r_mode;

    logic [PRE_W-1:0] w_pre_max;
    logic             w_tick;
    logic [DW:0]      w_lvl;
    logic [DW:0]      w_pk;
    logic [DW:0]      w_up;
    logic [DW:0]      w_dn;
    logic [PRE_W-1:0] w_nxt_pre;
    logic [DW-1:0]    w_nxt_level;
    logic             w_nxt_dir;
    logic             w_nxt_pulse;
    logic [DW-1:0]    w_nxt_duty;

    // A scale of 0 behaves as 1; ">=" also catches a scale lowered mid-count.
    assign w_pre_max = (scale == '0) ? '0 : scale - PRE_W'(1);
    assign w_tick    = (r_pre_cnt >= w_pre_max);

    assign w_lvl = {1'b0, r_level};
    assign w_pk  = {1'b0, peak};
    assign w_up  = w_lvl + c_STEP;
    assign w_dn  = w_lvl - c_STEP;

    always_comb begin
        w_nxt_pre   = r_pre_cnt;
        w_nxt_level = r_level;
        w_nxt_dir   = dir;
        w_nxt_pulse = 1'b0;
        if (mode != r_mode) begin
            w_nxt_pre   = '0;
            w_nxt_level = '0;
            w_nxt_dir   = 1'b1;
        end else if (mode != c_HOLD) begin
            w_nxt_pre = w_tick ? '0 : r_pre_cnt + PRE_W'(1);
            if (w_tick) begin
                if (mode == c_SAW) begin
                    w_nxt_dir = 1'b1;
                    if (w_lvl > w_pk) begin
                        w_nxt_level = peak;
                    end else if (w_up > w_pk) begin
                        w_nxt_level = '0;
                        w_nxt_pulse = 1'b1;
                    end else begin
                        w_nxt_level = w_up[DW-1:0];
                    end
                end else if (peak == '0) begin
                    // Degenerate waveform: every tick is a new period.
                    w_nxt_level = '0;
                    w_nxt_dir   = 1'b1;
                    w_nxt_pulse = 1'b1;
                end else if (w_lvl > w_pk) begin
                    w_nxt_level = peak;
                    w_nxt_dir   = 1'b0;
                end else if (dir) begin
                    if (w_up >= w_pk) begin
                        w_nxt_level = peak;
                        w_nxt_dir   = 1'b0;
                    end else begin
                        w_nxt_level = w_up[DW-1:0];
                    end
                end else if (w_lvl <= c_STEP) begin
                    w_nxt_level = '0;
                    w_nxt_dir   = 1'b1;
                    w_nxt_pulse = 1'b1;
                end else begin
                    w_nxt_level = w_dn[DW-1:0];
                end
            end
        end
        w_nxt_duty = (mode == c_SQR) ? (w_nxt_dir ? peak : '0) : w_nxt_level;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt    <= '0;
            r_level      <= '0;
            r_mode       <= mode;
            dir          <= 1'b1;
            duty_out     <= '0;
            period_pulse <= 1'b0;
        end else if (!enable) begin
            duty_out     <= '0;
            period_pulse <= 1'b0;
        end else begin
            r_pre_cnt    <= w_nxt_pre;
            r_level      <= w_nxt_level;
            r_mode       <= mode;
            dir          <= w_nxt_dir;
            duty_out     <= w_nxt_duty;
            period_pulse <= w_nxt_pulse;
        end
    end

    logic w_unused_tri;
    assign w_unused_tri = (c_TRI == 2'b00);

endmodule
`default_nettype wire
